pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Consumer end of the PLL lock interface. Takes the PLL's asynchronous lock output and generates staged, synchronous reset releases for downstream logic in one clock domain.
- Watches for loss of lock and re-asserts all resets when it happens.
- Requests a PLL reset when lock does not arrive within a timeout.
- Sits directly after the clock generator; its outputs feed the per-subsystem reset inputs of the SoC.

Parameters:
- SYNC_STAGES, 2, number of flops in the pll_locked synchronizer (must be ≥2).
- HOLDOFF_CYCLES, 1024, consecutive synchronized-lock cycles required before the first release (≥1).
- STAGES, 3, number of staged reset outputs (1..8).
- STAGE_GAP, 16, cycles between successive stage releases (≥1).
- LOCK_TIMEOUT, 65536, cycles waiting for lock before a PLL reset is requested (≥2).
- PLLRST_CYCLES, 8, width of the pll_rst pulse in cycles (≥1).
- CNT_W, 8, width of the lock-loss counter.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL LOCK output; asynchronous to clk.
- pll_rst  out  1  active-high reset request to the PLL RST pin.
- rst_stage  out  STAGES  active-high reset per subsystem; bit 0 is released first.
- ready  out  1  high when all stages are released and lock is held.
- lock_loss_cnt  out  CNT_W  saturating count of lock losses after release began.

Behaviour:
- Interface rule: single clock clk; reset is synchronous and active-high.
- Reset values:
  - synchronizer flops 0
  - rst_stage all 1
  - ready 0
  - pll_rst 0
  - lock_loss_cnt 0
  - state S_WAIT
  - all timers 0
- locked_s is the output of a SYNC_STAGES-deep synchronizer on pll_locked. Only locked_s is used internally.
- All outputs are registered. No combinational path from any input to any output.
- S_WAIT:
  - All stages asserted. Timer increments each cycle.
  - If locked_s=1, go to S_HOLD and clear the timer.
  - Else if timer==LOCK_TIMEOUT-1, go to S_PLLRST.
  - locked_s takes priority over the timeout in the same cycle.
- S_PLLRST:
  - pll_rst=1 for exactly PLLRST_CYCLES cycles, then go to S_WAIT with the timer cleared.
  - locked_s is ignored in this state.
- S_HOLD:
  - The counter increments while locked_s=1.
  - If locked_s=0, go to S_WAIT with the timer cleared. This is a glitch, not a lock loss; the counter is unchanged.
  - When the counter reaches HOLDOFF_CYCLES-1 with locked_s=1, go to S_REL.
- S_REL:
  - rst_stage[0] deasserts on the edge that enters S_REL.
  - rst_stage[i] deasserts i*STAGE_GAP cycles later.
  - When rst_stage[STAGES-1] deasserts, ready rises on the same edge and the state goes to S_RUN.
- S_RUN: outputs are held.
- Lock loss (locked_s=0 in S_REL or S_RUN):
  - On the next edge, all rst_stage bits return to 1, ready goes to 0, and lock_loss_cnt increments (saturating at all-ones).
  - State goes to S_WAIT with the timer cleared.
- Timing, with t = first cycle locked_s=1 is seen in S_WAIT:
  - rst_stage[0] falls at t+1+HOLDOFF_CYCLES.
  - rst_stage[i] falls at t+1+HOLDOFF_CYCLES+i*STAGE_GAP.
- STAGES=1: ready rises together with rst_stage[0].
- reset asserted in any state, including mid-release or during pll_rst: returns to the reset values on the next edge. pll_rst drops immediately.
- Counter widths: $clog2 of the respective parameter, minimum 1. No wrap-around is reachable.

Optional Feature:
- Macro: PLL_RESET_SEQ_LOSS_CNT_EN.
- Defined: lock_loss_cnt is implemented as specified above.
- Undefined: no counter register is built and lock_loss_cnt is tied to 0. All other behaviour is identical.

Test Plan:
Bench parameters for all scenarios: SYNC_STAGES=2, HOLDOFF=8, STAGES=3, GAP=4, TIMEOUT=32, PLLRST=4, CNT_W=8, macro defined. reset is released at cycle 0.
- Clean lock: pll_locked rises at cycle 10 and stays high -> locked_s at 12; rst_stage=110 at 21, 100 at 25, 000 at 29; ready=1 at 29; pll_rst stays 0.
- No lock: pll_locked held 0 -> pll_rst=1 for cycles 32–35, then again for cycles 68–71; rst_stage stays 111; ready stays 0.
- Hold-off glitch: lock rises, then drops for 1 cycle after 5 hold cycles -> rst_stage stays 111; lock_loss_cnt stays 0; release timing restarts from the next locked_s rise.
- Loss in RUN: after ready=1, pll_locked drops -> rst_stage=111 and ready=0 within 3 cycles; lock_loss_cnt=1; relocking repeats the 8/4/4 release timing.
- Saturation: 260 loss/relock cycles -> lock_loss_cnt=255, with no wrap to 0.
- Reset mid-release: assert reset while rst_stage=110 -> next edge gives rst_stage=111, ready=0, pll_rst=0, lock_loss_cnt=0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: staged reset release after PLL lock, with lock-loss re-reset and PLL reset on lock timeout.
// Optional lock-loss counter enabled by PLL_RESET_SEQ_LOSS_CNT_EN.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = 1024,
  parameter int STAGES         = 3,
  parameter int STAGE_GAP      = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int PLLRST_CYCLES  = 8,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pll_locked,
  output logic              pll_rst,
  output logic [STAGES-1:0] rst_stage,
  output logic              ready,
  output logic [CNT_W-1:0]  lock_loss_cnt
);
  localparam int TW_A = $clog2(LOCK_TIMEOUT) > $clog2(HOLDOFF_CYCLES) ? $clog2(LOCK_TIMEOUT) : $clog2(HOLDOFF_CYCLES);
  localparam int TW_B = $clog2(STAGE_GAP) > $clog2(PLLRST_CYCLES) ? $clog2(STAGE_GAP) : $clog2(PLLRST_CYCLES);
  localparam int TW_C = TW_A > TW_B ? TW_A : TW_B;
  localparam int TW   = TW_C < 1 ? 1 : TW_C;
  localparam logic [STAGES-1:0] REL0 = {STAGES{1'b1}} << 1;
  typedef enum logic [2:0] {S_WAIT, S_PLLRST, S_HOLD, S_REL, S_RUN} state_t;
  state_t                 state;
  logic [TW-1:0]          timer;
  logic [SYNC_STAGES-1:0] sync;
  logic                   locked_s;
  logic [STAGES-1:0]      rs_next;
  assign locked_s = sync[SYNC_STAGES-1];
  assign rs_next  = rst_stage << 1;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_WAIT;
      timer     <= '0;
      sync      <= '0;
      pll_rst   <= 1'b0;
      rst_stage <= '1;
      ready     <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pll_locked};
      case (state)
        S_WAIT: begin
          timer <= '0;
          if (!locked_s && timer == TW'(LOCK_TIMEOUT - 1)) begin
            state   <= S_PLLRST;
            pll_rst <= 1'b1;
          end else if (locked_s)
            state <= S_HOLD;
          else
            timer <= timer + 1'b1;
        end
        S_PLLRST: begin
          timer <= timer + 1'b1;
          if (timer == TW'(PLLRST_CYCLES - 1)) begin
            state   <= S_WAIT;
            timer   <= '0;
            pll_rst <= 1'b0;
          end
        end
        S_HOLD: begin
          timer <= timer + 1'b1;
          if (!locked_s) begin
            state <= S_WAIT;
            timer <= '0;
          end else if (timer == TW'(HOLDOFF_CYCLES - 1)) begin
            state     <= REL0 == '0 ? S_RUN : S_REL;
            rst_stage <= REL0;
            ready     <= REL0 == '0;
            timer     <= '0;
          end
        end
        S_REL, S_RUN: begin
          if (!locked_s) begin
            state     <= S_WAIT;
            timer     <= '0;
            rst_stage <= '1;
            ready     <= 1'b0;
          end else if (state == S_REL) begin
            timer <= timer + 1'b1;
            if (timer == TW'(STAGE_GAP - 1)) begin
              timer     <= '0;
              rst_stage <= rs_next;
              ready     <= rs_next == '0;
              state     <= rs_next == '0 ? S_RUN : S_REL;
            end
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
  logic [CNT_W-1:0] cnt;
  logic             loss;
  assign loss = (state == S_REL || state == S_RUN) && !locked_s;
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (loss && !(&cnt))
      cnt <= cnt + 1'b1;
  end
  assign lock_loss_cnt = cnt;
`else
  assign lock_loss_cnt = '0;
`endif
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: table-driven and hand-sequenced checks of pll_reset_sequencer via an expectation queue.
module tb_pll_reset_sequencer;
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  typedef struct {
    int         cyc;
    logic       lk;
    logic [2:0] rs;
    logic       rdy;
    logic       prst;
    logic [7:0] cnt;
  } vec_t;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic [2:0] rst_stage;
  logic       ready;
  logic [7:0] lock_loss_cnt;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         base;
  vec_t       q[$];
  vec_t       tbl[$];
  pll_reset_sequencer #(
    .SYNC_STAGES(2), .HOLDOFF_CYCLES(8), .STAGES(3), .STAGE_GAP(4),
    .LOCK_TIMEOUT(32), .PLLRST_CYCLES(4), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .rst_stage(rst_stage), .ready(ready), .lock_loss_cnt(lock_loss_cnt)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(int c, logic lk, logic [2:0] rs, logic rdy, logic prst, int cnt);
    vec_t v;
    v.cyc  = c;
    v.lk   = lk;
    v.rs   = rs;
    v.rdy  = rdy;
    v.prst = prst;
    v.cnt  = CNT_EN ? 8'(cnt > 255 ? 255 : cnt) : 8'd0;
    return v;
  endfunction
  task automatic expect_at(int c, logic [2:0] rs, logic rdy, logic prst, int cnt);
    q.push_back(mk(c, 1'b0, rs, rdy, prst, cnt));
  endtask
  task automatic check();
    vec_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_chk++;
      if (e.cyc < cyc)
        $display("FAIL missed cyc=%0d (now %0d)", e.cyc, cyc);
      else if (rst_stage !== e.rs || ready !== e.rdy || pll_rst !== e.prst || lock_loss_cnt !== e.cnt)
        $display("FAIL cyc=%0d got rst_stage=%b ready=%b pll_rst=%b cnt=%0d want %b %b %b %0d",
                 cyc, rst_stage, ready, pll_rst, lock_loss_cnt, e.rs, e.rdy, e.prst, e.cnt);
      else
        n_pass++;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check();
  endtask
  task automatic go(int n);
    while (cyc < n) tick();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    pll_locked = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask
  initial begin
    // clean lock, loss in RUN, relock
    tbl.push_back(mk( 0, 0, 3'b111, 0, 0, 0));
    tbl.push_back(mk(10, 1, 3'b111, 0, 0, 0));
    tbl.push_back(mk(20, 1, 3'b111, 0, 0, 0));
    tbl.push_back(mk(21, 1, 3'b110, 0, 0, 0));
    tbl.push_back(mk(24, 1, 3'b110, 0, 0, 0));
    tbl.push_back(mk(25, 1, 3'b100, 0, 0, 0));
    tbl.push_back(mk(28, 1, 3'b100, 0, 0, 0));
    tbl.push_back(mk(29, 1, 3'b000, 1, 0, 0));
    tbl.push_back(mk(40, 0, 3'b000, 1, 0, 0));
    tbl.push_back(mk(42, 0, 3'b000, 1, 0, 0));
    tbl.push_back(mk(43, 0, 3'b111, 0, 0, 1));
    tbl.push_back(mk(50, 1, 3'b111, 0, 0, 1));
    tbl.push_back(mk(60, 1, 3'b111, 0, 0, 1));
    tbl.push_back(mk(61, 1, 3'b110, 0, 0, 1));
    tbl.push_back(mk(65, 1, 3'b100, 0, 0, 1));
    tbl.push_back(mk(69, 1, 3'b000, 1, 0, 1));
    tbl.push_back(mk(75, 1, 3'b000, 1, 0, 1));
    do_reset();
    foreach (tbl[i]) q.push_back(tbl[i]);
    check();
    for (int i = 0; i < tbl.size(); i++) begin
      go(tbl[i].cyc);
      pll_locked = tbl[i].lk;
    end
    // no lock: periodic PLL reset pulses, then reset during a pulse
    do_reset();
    expect_at(31, 3'b111, 0, 0, 0);
    expect_at(32, 3'b111, 0, 1, 0);
    expect_at(35, 3'b111, 0, 1, 0);
    expect_at(36, 3'b111, 0, 0, 0);
    expect_at(67, 3'b111, 0, 0, 0);
    expect_at(68, 3'b111, 0, 1, 0);
    expect_at(71, 3'b111, 0, 1, 0);
    expect_at(72, 3'b111, 0, 0, 0);
    expect_at(105, 3'b111, 0, 1, 0);
    expect_at(106, 3'b111, 0, 0, 0);
    go(105);
    reset = 1'b1;
    go(106);
    // one-cycle glitch during hold-off restarts the release timing
    do_reset();
    expect_at(28, 3'b111, 0, 0, 0);
    expect_at(29, 3'b110, 0, 0, 0);
    expect_at(33, 3'b100, 0, 0, 0);
    expect_at(37, 3'b000, 1, 0, 0);
    go(10);
    pll_locked = 1'b1;
    go(17);
    pll_locked = 1'b0;
    go(18);
    pll_locked = 1'b1;
    go(38);
    // saturation: 260 loss/relock rounds, each losing lock while rst_stage=110
    do_reset();
    base = 10;
    for (int k = 0; k < 260; k++) begin
      expect_at(base + 11, 3'b110, 0, 0, k);
      expect_at(base + 14, 3'b111, 0, 0, k + 1);
      go(base);
      pll_locked = 1'b1;
      go(base + 11);
      pll_locked = 1'b0;
      go(base + 14);
      base += 15;
    end
    // reset mid-release
    expect_at(base + 11, 3'b110, 0, 0, 260);
    expect_at(base + 12, 3'b110, 0, 0, 260);
    expect_at(base + 13, 3'b111, 0, 0, 0);
    go(base);
    pll_locked = 1'b1;
    go(base + 12);
    reset = 1'b1;
    go(base + 13);
    reset = 1'b0;
    while (q.size() > 0) begin
      n_chk++;
      $display("FAIL unreached cyc=%0d", q[0].cyc);
      void'(q.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
